// File: rtl/usb_tx_encoder.sv
// USB low-level transmit encoder: SYNC, NRZI line coding with bit stuffing, EOP.
// Payload bytes arrive over a valid/ready handshake and go out LSB first.
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    input  logic       tx_last,
    output logic       tx_data_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_DATA    = 3'd2,
        ST_STUFF   = 3'd3,
        ST_EOP_SE0 = 3'd4,
        ST_EOP_J   = 3'd5
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [CW-1:0] bit_cnt_r;
    logic [CW-1:0] bit_cnt_next_s;
    logic [2:0]    bit_idx_r;
    logic [2:0]    bit_idx_next_s;
    logic [2:0]    idx_inc_s;
    logic [2:0]    ones_r;
    logic [2:0]    ones_next_s;
    logic [2:0]    ones_inc_s;
    logic [7:0]    shift_r;
    logic          last_r;
    logic          level_r;
    logic          level_next_s;
    logic          bit_end_s;
    logic          cur_bit_s;
    logic          boundary_s;
    logic          accept_s;
    logic          underrun_s;
    logic          new_bit_s;
    logic          nxt_bit_s;
    logic          se0_next_s;
    logic          d_plus_next_s;
    logic          d_minus_next_s;
    logic          busy_next_s;
    logic          done_next_s;

    assign bit_end_s  = (bit_cnt_r == CNT_MAX);
    assign idx_inc_s  = bit_idx_r + 3'd1;
    assign cur_bit_s  = shift_r[bit_idx_r];
    assign ones_inc_s = cur_bit_s ? (ones_r + 3'd1) : 3'd0;

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and bit sequencing; a pending stuff bit defers the byte boundary
    always_comb begin
        state_next_s   = state_r;
        bit_idx_next_s = bit_idx_r;
        ones_next_s    = ones_r;
        new_bit_s      = 1'b0;
        nxt_bit_s      = 1'b1;
        boundary_s     = 1'b0;
        accept_s       = 1'b0;
        underrun_s     = 1'b0;
        if ((state_r == ST_IDLE) || bit_end_s) begin
            bit_cnt_next_s = {CW{1'b0}};
        end else begin
            bit_cnt_next_s = bit_cnt_r + CNT_ONE;
        end
        case (state_r)
            ST_IDLE: begin
                if (tx_start) begin
                    state_next_s   = ST_SYNC;
                    bit_idx_next_s = 3'd0;
                    ones_next_s    = 3'd1;
                    new_bit_s      = 1'b1;
                    nxt_bit_s      = 1'b0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (bit_end_s && (bit_idx_r == 3'd7)) begin
                    boundary_s = 1'b1;
                end else if (bit_end_s) begin
                    bit_idx_next_s = idx_inc_s;
                    new_bit_s      = 1'b1;
                    nxt_bit_s      = (bit_idx_r == 3'd6);
                end else begin
                    state_next_s = ST_SYNC;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    ones_next_s = ones_inc_s;
                    if (ones_inc_s == 3'd6) begin
                        state_next_s = ST_STUFF;
                        ones_next_s  = 3'd0;
                        new_bit_s    = 1'b1;
                        nxt_bit_s    = 1'b0;
                    end else if (bit_idx_r == 3'd7) begin
                        boundary_s = 1'b1;
                    end else begin
                        bit_idx_next_s = idx_inc_s;
                        new_bit_s      = 1'b1;
                        nxt_bit_s      = shift_r[idx_inc_s];
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_STUFF: begin
                if (bit_end_s && (bit_idx_r == 3'd7)) begin
                    boundary_s = 1'b1;
                end else if (bit_end_s) begin
                    state_next_s   = ST_DATA;
                    bit_idx_next_s = idx_inc_s;
                    new_bit_s      = 1'b1;
                    nxt_bit_s      = shift_r[idx_inc_s];
                end else begin
                    state_next_s = ST_STUFF;
                end
            end
            ST_EOP_SE0: begin
                if (bit_end_s && (bit_idx_r == 3'd1)) begin
                    state_next_s = ST_EOP_J;
                end else if (bit_end_s) begin
                    bit_idx_next_s = idx_inc_s;
                end else begin
                    state_next_s = ST_EOP_SE0;
                end
            end
            ST_EOP_J: begin
                if (bit_end_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_EOP_J;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        // The latched last flag belongs to the previous packet while in SYNC
        if (boundary_s) begin
            bit_idx_next_s = 3'd0;
            if ((state_r != ST_SYNC) && last_r) begin
                state_next_s = ST_EOP_SE0;
            end else if (tx_data_valid) begin
                state_next_s = ST_DATA;
                accept_s     = 1'b1;
                new_bit_s    = 1'b1;
                nxt_bit_s    = tx_data[0];
            end else begin
                state_next_s = ST_EOP_SE0;
                underrun_s   = 1'b1;
            end
        end else begin
            accept_s = 1'b0;
        end
    end

    // Output decode: NRZI level, SE0 and status flags for the coming cycle
    always_comb begin
        busy_next_s = (state_next_s != ST_IDLE);
        done_next_s = (state_next_s == ST_EOP_J) && (bit_cnt_next_s == CNT_MAX);
        se0_next_s  = (state_next_s == ST_EOP_SE0);
        if ((state_next_s == ST_IDLE) || (state_next_s == ST_EOP_J)) begin
            level_next_s = 1'b1;
        end else if (new_bit_s) begin
            level_next_s = nxt_bit_s ? level_r : ~level_r;
        end else begin
            level_next_s = level_r;
        end
        if (se0_next_s) begin
            d_plus_next_s  = 1'b0;
            d_minus_next_s = 1'b0;
        end else begin
            d_plus_next_s  = level_next_s;
            d_minus_next_s = ~level_next_s;
        end
    end

    // Bit timing, shift data and ones-run bookkeeping
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt_r <= {CW{1'b0}};
            bit_idx_r <= 3'd0;
            ones_r    <= 3'd0;
            level_r   <= 1'b1;
            shift_r   <= 8'h00;
            last_r    <= 1'b0;
        end else begin
            bit_cnt_r <= bit_cnt_next_s;
            bit_idx_r <= bit_idx_next_s;
            ones_r    <= ones_next_s;
            level_r   <= level_next_s;
            if (accept_s) begin
                shift_r <= tx_data;
                last_r  <= tx_last;
            end else begin
                shift_r <= shift_r;
                last_r  <= last_r;
            end
        end
    end

    // Registered line and status outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            d_plus        <= 1'b1;
            d_minus       <= 1'b0;
            tx_busy       <= 1'b0;
            tx_data_ready <= 1'b0;
            tx_done       <= 1'b0;
            tx_error      <= 1'b0;
        end else begin
            d_plus        <= d_plus_next_s;
            d_minus       <= d_minus_next_s;
            tx_busy       <= busy_next_s;
            tx_data_ready <= accept_s;
            tx_done       <= done_next_s;
            tx_error      <= underrun_s;
        end
    end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Bench for usb_tx_encoder: a bit-level packet model builds the expected per-cycle
// line/status trace, which is compared against the encoder every clock.
module tb_usb_tx_encoder;
    localparam int CPB = 8;
    localparam logic [5:0] IDLE_V = 6'b10_0000; // {d_plus,d_minus,busy,ready,error,done}

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_data_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_data_ready;
    logic       d_plus;
    logic       d_minus;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    int         n_pass = 0;
    int         n_checks = 0;
    bit         chk_en = 1'b0;
    logic [5:0] exp_q[$];
    logic [7:0] pkt_bytes[8];
    int         pkt_n = 0;
    bit         pkt_under = 1'b0;

    always #5 clk = ~clk;

    usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_data(tx_data),
        .tx_data_valid(tx_data_valid), .tx_last(tx_last), .tx_data_ready(tx_data_ready),
        .d_plus(d_plus), .d_minus(d_minus), .tx_busy(tx_busy), .tx_done(tx_done),
        .tx_error(tx_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    endtask

    function automatic logic [5:0] dut_vec();
        return {d_plus, d_minus, tx_busy, tx_data_ready, tx_error, tx_done};
    endfunction

    // one line bit held for CPB cycles; pulses placed on first/last cycle of the bit
    task automatic push_bit(input logic dp, input logic dm, input logic rdy,
                            input logic err, input logic done);
        for (int c = 0; c < CPB; c++)
            exp_q.push_back({dp, dm, 1'b1, rdy && (c == 0), err && (c == 0), done && (c == CPB - 1)});
    endtask

    // packet model: bit list -> NRZI levels, stuffing after six 1s, EOP
    task automatic model_packet();
        logic lvl;
        logic b;
        int   ones;
        lvl = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b = (i == 7);
            if (!b) lvl = ~lvl;
            push_bit(lvl, ~lvl, 1'b0, 1'b0, 1'b0);
        end
        ones = 1;
        for (int k = 0; k < pkt_n; k++) begin
            for (int j = 0; j < 8; j++) begin
                b = pkt_bytes[k][j];
                if (!b) lvl = ~lvl;
                push_bit(lvl, ~lvl, j == 0, 1'b0, 1'b0);
                ones = b ? ones + 1 : 0;
                if (ones == 6) begin
                    lvl = ~lvl;
                    push_bit(lvl, ~lvl, 1'b0, 1'b0, 1'b0);
                    ones = 0;
                end
            end
        end
        push_bit(1'b0, 1'b0, 1'b0, pkt_under, 1'b0);
        push_bit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_bit(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic line_pattern(input int nbits, output logic [31:0] dp_v, output logic [31:0] dm_v);
        dp_v = 32'h0;
        dm_v = 32'h0;
        for (int i = 0; i < nbits; i++) begin
            dp_v[i] = exp_q[i * CPB][5];
            dm_v[i] = exp_q[i * CPB][4];
        end
    endtask

    function automatic int count_field(input int pos);
        int n;
        n = 0;
        foreach (exp_q[i]) if (exp_q[i][pos]) n++;
        return n;
    endfunction

    // the single per-cycle compare point, #1 after the active edge
    task automatic tick();
        logic [5:0] e;
        @(posedge clk);
        #1;
        if (chk_en) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_V;
            check("cycle", {26'h0, dut_vec()}, {26'h0, e});
        end
    endtask

    task automatic present(input int idx);
        if (idx < pkt_n) begin
            tx_data       = pkt_bytes[idx];
            tx_data_valid = 1'b1;
            tx_last       = !pkt_under && (idx == pkt_n - 1);
        end else begin
            tx_data       = 8'($urandom);
            tx_data_valid = 1'b0;
            tx_last       = 1'($urandom);
        end
    endtask

    task automatic run_packet(input bit extra_start);
        int idx;
        int start_at;
        int guard;
        model_packet();
        idx = 0;
        present(idx);
        tx_start = 1'b1;
        start_at = $urandom_range(60, 20);
        guard = 0;
        while (exp_q.size() > 0 && guard < 4000) begin
            tick();
            guard++;
            tx_start = extra_start && (guard == start_at);
            if (tx_data_ready) idx++;
            present(idx);
        end
        tx_start = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        logic [31:0] dp_v;
        logic [31:0] dm_v;
        logic [31:0] cnt;

        repeat (3) tick();
        check("reset_state", {26'h0, dut_vec()}, {26'h0, IDLE_V});
        n_rst = 1'b1;
        chk_en = 1'b1;
        repeat (2) tick();

        // single 0x00 byte: model pinned to hand-derived line pattern
        pkt_bytes[0] = 8'h00; pkt_n = 1; pkt_under = 1'b0;
        model_packet();
        check("len_00", exp_q.size(), 32'd152);
        line_pattern(19, dp_v, dm_v);
        check("dp_00", dp_v, 32'h4552A);
        check("dm_00", dm_v, 32'h0AAD5);
        exp_q.delete();
        run_packet(1'b0);

        // 0xFF: stuff after fifth data bit
        pkt_bytes[0] = 8'hFF; pkt_n = 1; pkt_under = 1'b0;
        model_packet();
        check("len_ff", exp_q.size(), 32'd160);
        line_pattern(20, dp_v, dm_v);
        check("dp_ff", dp_v, 32'h9E02A);
        check("dm_ff", dm_v, 32'h01FD5);
        exp_q.delete();
        run_packet(1'b0);

        // 0x3F, 0x01: stuff then second byte; stray tx_start mid-packet
        pkt_bytes[0] = 8'h3F; pkt_bytes[1] = 8'h01; pkt_n = 2; pkt_under = 1'b0;
        model_packet();
        check("len_3f01", exp_q.size(), 32'd224);
        cnt = count_field(2);
        check("rdy_3f01", cnt, 32'd2);
        exp_q.delete();
        run_packet(1'b1);

        // underrun after one non-last byte
        pkt_bytes[0] = 8'h00; pkt_n = 1; pkt_under = 1'b1;
        model_packet();
        check("len_under", exp_q.size(), 32'd152);
        check("err_pos", {31'h0, exp_q[128][1]}, 32'd1);
        exp_q.delete();
        run_packet(1'b0);

        // reset in the middle of DATA
        pkt_bytes[0] = 8'h00; pkt_bytes[1] = 8'hA5; pkt_n = 2; pkt_under = 1'b0;
        chk_en = 1'b0;
        present(0);
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        repeat (90) tick();
        check("busy_before_rst", {31'h0, tx_busy}, 32'd1);
        #2;
        n_rst = 1'b0;
        #1;
        check("reset_async", {26'h0, dut_vec()}, {26'h0, IDLE_V});
        repeat (3) tick();
        check("reset_hold", {26'h0, dut_vec()}, {26'h0, IDLE_V});
        exp_q.delete();
        n_rst = 1'b1;
        chk_en = 1'b1;
        repeat (2) tick();
        pkt_bytes[0] = 8'h00; pkt_n = 1; pkt_under = 1'b0;
        run_packet(1'b0);

        // randomized packets
        for (int p = 0; p < 30; p++) begin
            pkt_under = ($urandom_range(3, 0) == 0);
            pkt_n = pkt_under ? $urandom_range(2, 0) : $urandom_range(4, 1);
            for (int k = 0; k < 8; k++) begin
                case ($urandom_range(3, 0))
                    0: pkt_bytes[k] = 8'hFF;
                    1: pkt_bytes[k] = 8'h00;
                    default: pkt_bytes[k] = 8'($urandom);
                endcase
            end
            run_packet(p[0]);
            repeat ($urandom_range(3, 0)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/usb_tx_encoder.md
USB_TX_ENCODER -- requirements
Module: usb_tx_encoder

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, meaning clock cycles per USB bit time.
REQ-002 SHALL have port clk  input  1  system clock; the block SHALL run on this single clock.
REQ-003 SHALL have port n_rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port tx_start  input  1  one-cycle request to begin a packet.
REQ-005 SHALL have port tx_data  input  8  next payload byte, sent LSB first.
REQ-006 SHALL have port tx_data_valid  input  1  tx_data/tx_last hold a byte.
REQ-007 SHALL have port tx_last  input  1  accompanying byte is the final payload byte.
REQ-008 SHALL have port tx_data_ready  output  1  one-cycle pulse marking byte acceptance.
REQ-009 SHALL have port d_plus  output  1  USB D+ line.
REQ-010 SHALL have port d_minus  output  1  USB D- line.
REQ-011 SHALL have port tx_busy  output  1  packet in progress (any state but IDLE).
REQ-012 SHALL have port tx_done  output  1  one-cycle pulse at packet completion.
REQ-013 SHALL have port tx_error  output  1  one-cycle pulse on data underrun.

Function
REQ-014 SHALL use line states J = (d_plus 1, d_minus 0), K = (0,1), SE0 = (0,0); IDLE drives J.
REQ-015 SHALL implement states IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J.
REQ-016 SHALL sample tx_start only in IDLE; tx_start in any other state SHALL be ignored.
REQ-017 SHALL enter SYNC on the cycle after tx_start; the first SYNC bit appears on the lines that cycle.
REQ-018 SHALL hold every line bit for exactly CLKS_PER_BIT cycles using a bit-time counter that wraps from CLKS_PER_BIT-1 to 0.
REQ-019 SHALL NRZI-encode: bit 0 toggles J/K; bit 1 holds the previous state.
REQ-020 SHALL send SYNC as 8'h80 LSB first (seven 0s, one 1), giving KJKJKJKK from idle J.
REQ-021 SHALL take a byte at each byte boundary (last bit-time cycle of SYNC's or DATA's 8th bit) only if tx_data_valid=1, asserting tx_data_ready for that single cycle and latching tx_data and tx_last.
REQ-022 SHALL, when a byte completes with latched tx_last=1, enter EOP_SE0 instead of loading a new byte; tx_data_ready SHALL NOT pulse then.
REQ-023 SHALL count consecutive transmitted 1s in DATA; the count resets on every 0 and after every stuffed bit.
REQ-024 SHALL, after the sixth consecutive 1, insert one STUFF bit time (a 0, i.e. toggle) before the next data bit or before EOP, consuming no data bit.
REQ-025 SHALL NOT apply stuffing to SYNC bits; the ones count SHALL start at 1 entering DATA (SYNC ends in a 1).
REQ-026 SHALL defer a byte boundary coinciding with a pending stuff until the STUFF bit completes.
REQ-027 SHALL, if tx_data_valid=0 at a non-last byte boundary (underrun), pulse tx_error that cycle and go to EOP_SE0.
REQ-028 SHALL drive SE0 for 2 bit times in EOP_SE0, then J for 1 bit time in EOP_J, then return to IDLE.
REQ-029 SHALL pulse tx_done on the last cycle of EOP_J, including after an underrun.
REQ-030 SHALL keep tx_data_ready, tx_done, and tx_error registered, each high for exactly one cycle per event.

Reset
REQ-031 SHALL, while n_rst=0 and asynchronously on its assertion, force state IDLE, d_plus=1, d_minus=0, tx_busy=0, tx_data_ready=0, tx_done=0, tx_error=0, and clear all counters and latched data.
REQ-032 SHALL abort any in-progress packet on reset with no EOP and no tx_done; after release it SHALL accept a new tx_start normally.

Verification
REQ-033 Reset: assert n_rst=0 mid-DATA -> lines J within same cycle, tx_busy=0; release and tx_start -> fresh SYNC KJKJKJKK.
REQ-034 Single byte 8'h00, tx_last=1 -> SYNC, then JKJKJKJK, SE0 SE0 J; 19 bit times (152 clk); tx_done once; tx_data_ready once.
REQ-035 Byte 8'hFF, tx_last=1 -> after SYNC: K×5, stuff J, J×3, then EOP; 9 data-phase bit times; stuff occurs after the 5th data bit (sync's trailing 1 counts).
REQ-036 Two bytes 8'h3F then 8'h01 (last) -> stuff bit inserted after the 5th data bit; second byte loaded only after the stuff; tx_data_ready pulses exactly twice.
REQ-037 Underrun: first byte tx_last=0, then tx_data_valid=0 at next boundary -> tx_error pulse at that boundary cycle, SE0 SE0 J, tx_done pulse.
REQ-038 tx_start re-asserted during DATA -> ignored; exactly one packet emitted; bit widths all exactly CLKS_PER_BIT cycles.
